code_lock_sender: RTL

Serial key transmitter for the team's 7-bit serial code lock; it drives the lock's single-bit input `IN`. On a start request it latches a parallel code and synchronises to the lock's frame boundary using the lock's `ERROR`/`UNLOCK` status lines. It then shifts the code out MSB-first, one bit per clock, and checks the verdict. A failed attempt is retried up to a bounded count.

---
 rtl/code_lock_sender.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/code_lock_sender.sv
// Purpose: serial key sender for the 7-bit code lock; syncs on ERROR/UNLOCK, shifts code MSB-first, retries.
// Latency: start -> SYNC in 1 cycle; first code bit lands while the lock sits in its start state; done 1 cycle after the verdict state.
// Backpressure: none; start is only sampled in IDLE and is ignored while busy.
module code_lock_sender #(
    parameter int CODE_LEN     = 7,
    parameter int MAX_TRIES    = 3,
    parameter int TRY_W        = 2,
    parameter int SYNC_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                start,
    input  logic [CODE_LEN-1:0] code_in,
    input  logic                error_in,
    input  logic                unlock_in,
    output logic                tx,
    output logic                busy,
    output logic                done,
    output logic                ok,
    output logic                fail,
    output logic [TRY_W-1:0]    attempts
);

    localparam int IDX_W = $clog2(CODE_LEN + 1);
    localparam int CNT_W = $clog2(SYNC_TIMEOUT + 1);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CODE_LEN);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYNC_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [TRY_W-1:0] TRY_MAX  = TRY_W'(MAX_TRIES);
    localparam logic [TRY_W-1:0] TRY_ONE  = TRY_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_KICK,
        ST_SEND,
        ST_CHECK,
        ST_RETRY,
        ST_OK,
        ST_FAIL
    } state_t;

    state_t              state_q, state_d;
    logic                tx_q, tx_d;
    logic                done_q, done_d;
    logic                ok_q, ok_d;
    logic                fail_q, fail_d;
    logic [TRY_W-1:0]    att_q, att_d;
    logic [CODE_LEN-1:0] sr_q, sr_d;     // latched code, kept intact across retries
    logic [CODE_LEN-1:0] sh_q, sh_d;     // working copy shifted out during one frame
    logic [IDX_W-1:0]    idx_q, idx_d;   // number of code bits already driven onto tx
    logic [CNT_W-1:0]    cnt_q, cnt_d;   // cycles spent in SYNC for this attempt
    logic                err_q, err_d;   // previous ERROR sample; with a current high sample it marks error2

    // Next-state and registered-output computation for the whole sender.
    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        done_d  = 1'b0;
        ok_d    = ok_q;
        fail_d  = fail_q;
        att_d   = att_q;
        sr_d    = sr_q;
        sh_d    = sh_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        err_d   = error_in;

        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b0;
                if (start) begin
                    sr_d    = code_in;
                    ok_d    = 1'b0;
                    fail_d  = 1'b0;
                    att_d   = TRY_ONE;
                    cnt_d   = '0;
                    state_d = ST_SYNC;
                end
            end

            ST_SYNC: begin
                tx_d = 1'b0;
                if (err_q && error_in) begin
                    // Lock is in error2 and returns to its start state on this edge.
                    tx_d    = sr_q[CODE_LEN-1];
                    sh_d    = sr_q << 1;
                    idx_d   = IDX_ONE;
                    state_d = ST_SEND;
                end else if (unlock_in) begin
                    // A 1 while unlocked sends the lock back to its start state.
                    tx_d    = 1'b1;
                    state_d = ST_KICK;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_FAIL;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            ST_KICK: begin
                tx_d    = sr_q[CODE_LEN-1];
                sh_d    = sr_q << 1;
                idx_d   = IDX_ONE;
                state_d = ST_SEND;
            end

            ST_SEND: begin
                if (error_in) begin
                    // Lock rejected an earlier bit; the frame is lost.
                    tx_d    = 1'b0;
                    state_d = ST_RETRY;
                end else if (idx_q == IDX_LAST) begin
                    tx_d    = 1'b0;
                    state_d = ST_CHECK;
                end else begin
                    tx_d  = sh_q[CODE_LEN-1];
                    sh_d  = sh_q << 1;
                    idx_d = idx_q + IDX_ONE;
                end
            end

            ST_CHECK: begin
                tx_d = 1'b0;
                if (unlock_in) begin
                    state_d = ST_OK;
                end else begin
                    state_d = ST_RETRY;
                end
            end

            ST_RETRY: begin
                tx_d = 1'b0;
                if (att_q == TRY_MAX) begin
                    state_d = ST_FAIL;
                end else begin
                    att_d   = att_q + TRY_ONE;
                    cnt_d   = '0;
                    state_d = ST_SYNC;
                end
            end

            ST_OK: begin
                // tx stays 0 so the lock remains in its unlock state.
                tx_d    = 1'b0;
                ok_d    = 1'b1;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end

            ST_FAIL: begin
                tx_d    = 1'b0;
                fail_d  = 1'b1;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                tx_d    = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset clears everything at once, so no done pulse escapes.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            tx_q    <= 1'b0;
            done_q  <= 1'b0;
            ok_q    <= 1'b0;
            fail_q  <= 1'b0;
            att_q   <= '0;
            sr_q    <= '0;
            sh_q    <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
            ok_q    <= ok_d;
            fail_q  <= fail_d;
            att_q   <= att_d;
            sr_q    <= sr_d;
            sh_q    <= sh_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign tx       = tx_q;
    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;
    assign ok       = ok_q;
    assign fail     = fail_q;
    assign attempts = att_q;

endmodule
